// File: rtl/y_mon_pkg.sv
// rtl/y_mon_pkg.sv - shared types and default sizes for the y pulse monitor
package y_mon_pkg;

  // Pulse-measurement FSM: idle between pulses, or timing a high pulse
  typedef enum logic {
    LOW  = 1'b0,
    HIGH = 1'b1
  } mon_state_t;

  localparam int DEF_DEB_CYCLES = 4;
  localparam int DEF_WIDTH_W    = 8;
  localparam int DEF_CNT_W      = 16;

endpackage

// File: rtl/sync_debounce.sv
// rtl/sync_debounce.sv - two-flop synchroniser followed by a level debouncer
module sync_debounce #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic level
);

  // Counter only needs to reach DEB_CYCLES-1: the edge after that is the toggle edge
  localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] stab_cnt;

  // Synchronise din, then accept a new level only after it has differed for DEB_CYCLES cycles
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1    <= 1'b0;
      sync2    <= 1'b0;
      level    <= 1'b0;
      stab_cnt <= '0;
    end else begin
      sync1 <= din;
      sync2 <= sync1;
      if (sync2 != level) begin
        if (stab_cnt == LAST) begin
          level    <= sync2;
          stab_cnt <= '0;
        end else begin
          stab_cnt <= stab_cnt + CW'(1);
        end
      end else begin
        stab_cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/y_pulse_monitor.sv
// rtl/y_pulse_monitor.sv - debounces y, measures each high pulse and reports its width
module y_pulse_monitor
  import y_mon_pkg::*;
#(
  parameter int DEB_CYCLES = DEF_DEB_CYCLES,
  parameter int WIDTH_W    = DEF_WIDTH_W,
  parameter int CNT_W      = DEF_CNT_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               y_in,
  input  logic               clr,
  input  logic               rpt_ready,
  output logic               rpt_valid,
  output logic [WIDTH_W-1:0] rpt_width,
  output logic               rpt_sat,
  output logic [CNT_W-1:0]   pulse_count,
  output logic               overrun,
  output logic               y_level
);

  mon_state_t         state;
  logic [WIDTH_W-1:0] width;
  logic               sat;
  logic               level;
  logic               complete;
  logic               take;

  sync_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_deb (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (y_in),
    .level (level)
  );

  assign y_level = level;

  // A pulse completes on the edge the FSM leaves HIGH; a transfer frees the report slot
  always_comb begin
    complete = (state == HIGH) && !level;
    take     = rpt_valid && rpt_ready;
  end

  // Pulse FSM with saturating width counter
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= LOW;
      width <= '0;
      sat   <= 1'b0;
    end else begin
      case (state)
        LOW: begin
          if (level) begin
            state <= HIGH;
            width <= WIDTH_W'(1);
            sat   <= 1'b0;
          end
        end
        HIGH: begin
          if (level) begin
            if (width == '1) begin
              sat <= 1'b1;
            end else begin
              width <= width + WIDTH_W'(1);
            end
          end else begin
            state <= LOW;
          end
        end
        default: state <= LOW;
      endcase
    end
  end

  // Single-entry report slot; a completion that finds it occupied is dropped and flagged
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rpt_valid <= 1'b0;
      rpt_width <= '0;
      rpt_sat   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (complete && (!rpt_valid || take)) begin
        rpt_valid <= 1'b1;
        rpt_width <= width;
        rpt_sat   <= sat;
      end else if (take) begin
        rpt_valid <= 1'b0;
      end
      if (clr) begin
        overrun <= 1'b0;
      end else if (complete && rpt_valid && !take) begin
        overrun <= 1'b1;
      end
    end
  end

  // Saturating completed-pulse counter; clr takes priority over a coincident completion
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse_count <= '0;
    end else if (clr) begin
      pulse_count <= '0;
    end else if (complete && (pulse_count != '1)) begin
      pulse_count <= pulse_count + CNT_W'(1);
    end
  end

endmodule
